// File: rtl/pulse_event_counter.sv
// Qualifies synchronised pulse_en high periods of at least MIN_W cycles and presents
// each one as a timestamped, numbered record through a one-entry valid/ready register.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   WAIT_LOW | armed only after s2 is seen low (reset/clear or mid-pulse)
//   IDLE     | waiting for a rising s2
//   HIGH     | measuring the high period, hi_len saturates at MIN_W
module pulse_event_counter #(
  parameter int N     = 32,
  parameter int MIN_W = 2
) (
  input  logic         rd_clk,
  input  logic         rd_resetn,
  input  logic         pulse_en,
  input  logic         clear,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [N-1:0] evt_count,
  output logic [N-1:0] evt_time,
  output logic         overflow
);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

  localparam logic [7:0]   MIN_W_L = 8'(MIN_W);
  localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_s1;
  logic         r_s2;
  logic [7:0]   r_hi_len;
  logic [7:0]   w_hi_len_nxt;
  logic         w_capture;
  logic         w_qualify;
  logic         w_accept;
  logic [N-1:0] r_timer;
  logic [N-1:0] r_time_cap;
  logic [N-1:0] r_evt_cnt;
  logic [N-1:0] w_evt_cnt_inc;
  logic         r_evt_valid;
  logic [N-1:0] r_evt_count;
  logic [N-1:0] r_evt_time;
  logic         r_overflow;

  // Synchroniser resets high so a level already present at release is not a new edge.
  always_ff @(posedge rd_clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= pulse_en;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      r_state  <= WAIT_LOW;
      r_hi_len <= 8'd0;
    end else if (clear) begin
      r_state  <= WAIT_LOW;
      r_hi_len <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_hi_len <= w_hi_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hi_len_nxt = r_hi_len;
    w_capture    = 1'b0;
    w_qualify    = 1'b0;
    case (r_state)
      WAIT_LOW: begin
        if (!r_s2) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (r_s2) begin
          w_state_nxt  = HIGH;
          w_capture    = 1'b1;
          w_hi_len_nxt = 8'd1;
        end
      end
      HIGH: begin
        if (r_s2) begin
          if (r_hi_len < MIN_W_L) w_hi_len_nxt = r_hi_len + 8'd1;
        end else begin
          w_state_nxt = IDLE;
          w_qualify   = (r_hi_len >= MIN_W_L);
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      r_timer    <= '0;
      r_time_cap <= '0;
    end else begin
      r_timer <= clear ? '0 : (r_timer + ONE_N);
      if (w_capture && !clear) r_time_cap <= r_timer;
    end
  end

  assign w_accept      = r_evt_valid & evt_ready;
  assign w_evt_cnt_inc = r_evt_cnt + ONE_N;

  // A full, unaccepted register drops the new record but the event is still numbered.
  always_ff @(posedge rd_clk or negedge rd_resetn) begin
    if (!rd_resetn) begin
      r_evt_cnt   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_count <= '0;
      r_evt_time  <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_evt_cnt   <= '0;
      r_evt_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_qualify) begin
      r_evt_cnt <= w_evt_cnt_inc;
      if (!r_evt_valid || evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_count <= w_evt_cnt_inc;
        r_evt_time  <= r_time_cap;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_accept) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_count = r_evt_count;
  assign evt_time  = r_evt_time;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_event_counter.sv
// Bench for pulse_event_counter: a run-length reference model checks every cycle,
// plus a width table, directed corner sequences and a randomized phase.
module tb_pulse_event_counter;
  localparam int N     = 32;
  localparam int MIN_W = 2;

  logic         rd_clk    = 1'b0;
  logic         rd_resetn = 1'b0;
  logic         pulse_en  = 1'b0;
  logic         clear     = 1'b0;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic         overflow;
  logic [N-1:0] evt_count;
  logic [N-1:0] evt_time;

  int checks = 0;
  int errors = 0;

  pulse_event_counter #(.N(N), .MIN_W(MIN_W)) dut (
    .rd_clk    (rd_clk),
    .rd_resetn (rd_resetn),
    .pulse_en  (pulse_en),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .evt_time  (evt_time),
    .overflow  (overflow)
  );

  always #5 rd_clk = ~rd_clk;

  // Reference model: pulse_en seen two edges late, high runs measured as plain lengths.
  bit           m_d1, m_d2, m_armed, m_valid, m_ovf;
  int           m_run;
  logic [N-1:0] m_timer, m_tcap, m_evcnt, m_cnt, m_time;

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1; m_d2 = 1; m_armed = 0; m_run = 0;
    m_timer = '0; m_tcap = '0; m_evcnt = '0;
    m_valid = 0; m_cnt = '0; m_time = '0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit s2 = m_d2;
    bit q  = 0;
    if (clear) begin
      m_timer = '0; m_evcnt = '0; m_ovf = 0; m_valid = 0; m_armed = 0; m_run = 0;
    end else begin
      if (!m_armed) begin
        if (!s2) m_armed = 1;
      end else if (m_run == 0) begin
        if (s2) begin m_run = 1; m_tcap = m_timer; end
      end else if (s2) begin
        m_run++;
      end else begin
        q = (m_run >= MIN_W);
        m_run = 0;
      end
      m_timer = m_timer + 1;
      if (q) begin
        m_evcnt = m_evcnt + 1;
        if (!m_valid || evt_ready) begin
          m_valid = 1; m_cnt = m_evcnt; m_time = m_tcap;
        end else begin
          m_ovf = 1;
        end
      end else if (m_valid && evt_ready) begin
        m_valid = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = pulse_en;
  endtask

  task automatic check_model();
    chk("evt_valid", N'(evt_valid), N'(m_valid));
    chk("overflow", N'(overflow), N'(m_ovf));
    chk("evt_count", evt_count, m_cnt);
    chk("evt_time", evt_time, m_time);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic pe, input logic rdy, input logic clr);
    check_model();
    pulse_en  = pe;
    evt_ready = rdy;
    clear     = clr;
    @(posedge rd_clk);
    model_edge();
    @(negedge rd_clk);
  endtask

  task automatic do_reset(input logic pe);
    @(negedge rd_clk);
    rd_resetn = 1'b0;
    pulse_en  = pe;
    clear     = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", N'(evt_valid), N'(0));
    chk("rst_overflow", N'(overflow), N'(0));
    chk("rst_count", evt_count, N'(0));
    chk("rst_time", evt_time, N'(0));
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_resetn = 1'b1;
  endtask

  task automatic pulse(input int len, input int gap, input logic rdy, output int seen);
    seen = 0;
    for (int k = 0; k < len + gap; k++) begin
      step(k < len, rdy, 1'b0);
      if (evt_valid) seen++;
    end
  endtask

  typedef struct {
    int len;
    int exp_evt;
    int exp_cnt;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   seen, first, nvalid, rem;
    logic lvl, rdy, clr;

    tbl[0] = '{len: 1, exp_evt: 0, exp_cnt: 0};
    tbl[1] = '{len: 2, exp_evt: 1, exp_cnt: 1};
    tbl[2] = '{len: 3, exp_evt: 1, exp_cnt: 2};
    tbl[3] = '{len: 1, exp_evt: 0, exp_cnt: 2};
    tbl[4] = '{len: 6, exp_evt: 1, exp_cnt: 3};
    tbl[5] = '{len: 2, exp_evt: 1, exp_cnt: 4};

    // Basic latency: 3-cycle pulse, record 5 edges after first high sample.
    do_reset(1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    first = -1; nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      step(k < 3, 1'b1, 1'b0);
      if (evt_valid) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    chk("latency", N'(first), N'(5));
    chk("valid_cycles", N'(nvalid), N'(1));
    chk("first_count", evt_count, N'(1));
    chk("first_time", evt_time, N'(5));

    // Width table.
    do_reset(1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].len, 8, 1'b1, seen);
      chk($sformatf("tbl%0d_evt", i), N'(seen != 0), N'(tbl[i].exp_evt));
      chk($sformatf("tbl%0d_cnt", i), evt_count, N'(tbl[i].exp_cnt));
    end

    // Runt pulse then a valid one.
    do_reset(1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    pulse(1, 8, 1'b1, seen);
    chk("runt_seen", N'(seen), N'(0));
    pulse(4, 8, 1'b1, seen);
    chk("after_runt_cnt", evt_count, N'(1));

    // Back-pressure: three events with no consumer.
    do_reset(1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    repeat (3) pulse(3, 6, 1'b0, seen);
    chk("bp_count", evt_count, N'(1));
    chk("bp_valid", N'(evt_valid), N'(1));
    chk("bp_overflow", N'(overflow), N'(1));
    step(1'b0, 1'b1, 1'b0);
    chk("bp_accept_valid", N'(evt_valid), N'(0));
    chk("bp_overflow_sticky", N'(overflow), N'(1));
    pulse(3, 8, 1'b1, seen);
    chk("bp_next_count", evt_count, N'(4));

    // Qualification on the same edge as acceptance of the held record.
    do_reset(1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    pulse(3, 6, 1'b0, seen);
    for (int k = 0; k < 10; k++) step(k < 3, k == 5, 1'b0);
    chk("coinc_valid", N'(evt_valid), N'(1));
    chk("coinc_count", evt_count, N'(2));
    chk("coinc_overflow", N'(overflow), N'(0));

    // Level high through reset release, then clear mid-pulse.
    do_reset(1'b1);
    pulse(10, 0, 1'b1, seen);
    chk("held_high_seen", N'(seen), N'(0));
    repeat (4) step(1'b0, 1'b1, 1'b0);
    pulse(3, 8, 1'b1, seen);
    chk("rearm_count", evt_count, N'(1));
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      step(k < 5, 1'b1, k == 3);
      if (evt_valid) seen++;
    end
    chk("clear_pulse_seen", N'(seen), N'(0));
    pulse(3, 8, 1'b1, seen);
    chk("post_clear_seen", N'(seen), N'(1));
    chk("post_clear_count", evt_count, N'(1));

    // Randomized traffic against the model.
    do_reset(1'b0);
    lvl = 1'b0; rem = 3;
    for (int i = 0; i < 4000; i++) begin
      if (rem == 0) begin
        lvl = ~lvl;
        rem = lvl ? $urandom_range(1, 5) : $urandom_range(1, 7);
      end
      rem--;
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(lvl);
      step(lvl, rdy, clr);
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_event_counter.md
PULSE_EVENT_COUNTER -- requirements
Module: pulse_event_counter

Interface
REQ-001 Parameter N, default 32: width of event count and timestamp.
REQ-002 Parameter MIN_W, default 2, legal 1..255: minimum synchronised high cycles for a valid event.
REQ-003 rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rd_resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 pulse_en  input  1  stretched pulse level from the upstream pulse stretcher; asynchronous to rd_clk.
REQ-006 clear  input  1  synchronous clear of counters, flags and pending event.
REQ-007 evt_valid  output  1  event record available.
REQ-008 evt_ready  input  1  consumer accepts record when evt_valid && evt_ready on a rising edge.
REQ-009 evt_count  output  N  running event number of the presented record.
REQ-010 evt_time  output  N  timestamp of the presented record.
REQ-011 overflow  output  1  sticky: at least one qualified event dropped.

Function
REQ-012 pulse_en SHALL pass through a 2-flop synchroniser (s1, s2); only s2 feeds logic.
REQ-013 A free-running timer SHALL increment by 1 every cycle, wrapping 2^N-1 -> 0.
REQ-014 FSM states SHALL be WAIT_LOW, IDLE, HIGH.
REQ-015 WAIT_LOW: stay while s2=1; go IDLE on first cycle s2=0.
REQ-016 IDLE: on s2=1 go HIGH, capture timer value into time_cap, set hi_len=1.
REQ-017 HIGH: while s2=1 increment hi_len, saturating at MIN_W; on s2=0 go IDLE and qualify event iff hi_len >= MIN_W, else discard silently.
REQ-018 Latency: if pulse_en is high for L consecutive edges (L >= MIN_W) starting edge t0, evt_valid SHALL rise after edge t0+L+2.
REQ-019 Each qualified event SHALL increment an internal event counter (wraps at 2^N); the post-increment value is the record's evt_count.
REQ-020 Output is a one-entry register: a qualified event loads evt_count/evt_time and sets evt_valid if the register is empty or is being accepted that same cycle.
REQ-021 Qualified event while evt_valid=1 and evt_ready=0: record SHALL be dropped, held record unchanged, overflow set; event counter still increments.
REQ-022 Acceptance without new event SHALL clear evt_valid next cycle; evt_count/evt_time hold last values.
REQ-023 evt_count/evt_time SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-024 clear=1 SHALL, next edge: zero event counter, timer, overflow; clear evt_valid; force FSM to WAIT_LOW (a pulse in progress is not counted); clear dominates a simultaneous qualification.

Reset
REQ-025 rd_resetn=0 SHALL asynchronously set: s1=s2=1, FSM=WAIT_LOW, timer=0, event counter=0, hi_len=0, evt_valid=0, evt_count=0, evt_time=0, overflow=0.
REQ-026 A pulse_en level already high at reset release SHALL NOT produce an event; reset mid-pulse discards it.
REQ-027 After deassertion, logic SHALL act from the first rd_clk rising edge.

Verification
REQ-028 Reset release with pulse_en=0, then pulse_en high 3 cycles, evt_ready=1 -> one evt_valid cycle, evt_count=1, evt_valid 5 edges after first high sample.
REQ-029 pulse_en high 1 cycle with MIN_W=2 -> no evt_valid, event counter unchanged; next 4-cycle pulse -> evt_count=1.
REQ-030 evt_ready=0, three qualified pulses -> evt_count=1 held, overflow=1; raise evt_ready -> one accept, evt_valid low, next event evt_count=4.
REQ-031 Qualification coincident with acceptance of prior record -> new record loaded, evt_valid stays 1, overflow stays 0.
REQ-032 pulse_en high through reset release -> no event until pulse_en low then high again; clear asserted mid-pulse -> no event for that pulse, counters 0.
